// File: rtl/upsp_frame_ctrl_if.sv
// upsp_frame_ctrl_if
//   Bundles the frame sequencer's request/stream/done inputs and its
//   pulse/counter/status outputs.
//   master : configuration + stream side (drives requests, beats, done flags)
//   slave  : upsp_frame_ctrl (drives pulses, counters, status)
interface upsp_frame_ctrl_if #(
    parameter int N_PARALLEL     = 2,
    parameter int CRF_DATA_WIDTH = 32,
    parameter int SRC_IMG_HEIGHT = 1080
);
    localparam int ROW_W = $clog2(SRC_IMG_HEIGHT + 1);

    logic                      cfg_start;
    logic                      cfg_abort;
    logic                      in_hsk;
    logic                      in_tlast;
    logic [N_PARALLEL-1:0]     upsp_done;
    logic                      up_start;
    logic                      up_end;
    logic [CRF_DATA_WIDTH-1:0] up_inhskcnt;
    logic [ROW_W-1:0]          row_cnt;
    logic                      busy;
    logic                      irq_done;
    logic [3:0]                status;

    modport master (
        output cfg_start, cfg_abort, in_hsk, in_tlast, upsp_done,
        input  up_start, up_end, up_inhskcnt, row_cnt, busy, irq_done, status
    );

    modport slave (
        input  cfg_start, cfg_abort, in_hsk, in_tlast, upsp_done,
        output up_start, up_end, up_inhskcnt, row_cnt, busy, irq_done, status
    );
endinterface

// File: rtl/upsp_frame_ctrl.sv
// upsp_frame_ctrl
//   Frame-level sequencer for the AXI-Stream input path into Up-Sampling.
//   Turns start/abort requests into one-cycle UPSTART/UPEND pulses, counts
//   accepted input beats, checks tlast row alignment and gathers the
//   per-element done flags before closing the frame.
// Ports
//   clk, rst_n (async, active-low)
//   bus.slave : cfg_start, cfg_abort, in_hsk, in_tlast, upsp_done  (in)
//               up_start, up_end, up_inhskcnt, row_cnt, busy,
//               irq_done, status = {aborted, err_stray, err_tlast, frame_ok}
module upsp_frame_ctrl #(
    parameter int SRC_IMG_WIDTH  = 1920,
    parameter int SRC_IMG_HEIGHT = 1080,
    parameter int N_PARALLEL     = 2,
    parameter int CRF_DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    upsp_frame_ctrl_if.slave bus
);
    localparam int ROW_W = $clog2(SRC_IMG_HEIGHT + 1);
    localparam int COL_W = (SRC_IMG_WIDTH > 1) ? $clog2(SRC_IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0]          COL_LAST = COL_W'(SRC_IMG_WIDTH - 1);
    localparam logic [CRF_DATA_WIDTH-1:0] PIX_M1   =
        CRF_DATA_WIDTH'(SRC_IMG_WIDTH * SRC_IMG_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_END    = 3'd4
    } state_e;

    state_e                    state_q;
    logic                      up_start_q, up_end_q, irq_done_q, busy_q;
    logic [CRF_DATA_WIDTH-1:0] cnt_q;
    logic [ROW_W-1:0]          row_q;
    logic [COL_W-1:0]          col_q;
    logic [N_PARALLEL-1:0]     done_seen_q;
    logic                      aborted_q, err_stray_q, err_tlast_q, frame_ok_q;

    logic col_at_last;
    logic done_all;

    assign col_at_last = (col_q == COL_LAST);
    // Include this cycle's done flags so UPEND follows the last done by
    // exactly one cycle instead of waiting for done_seen to register first.
    assign done_all    = &(done_seen_q | bus.upsp_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            up_start_q  <= 1'b0;
            up_end_q    <= 1'b0;
            irq_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            done_seen_q <= '0;
            aborted_q   <= 1'b0;
            err_stray_q <= 1'b0;
            err_tlast_q <= 1'b0;
            frame_ok_q  <= 1'b0;
        end else begin
            up_start_q <= 1'b0;
            up_end_q   <= 1'b0;
            irq_done_q <= 1'b0;

            if (state_q == S_STREAM || state_q == S_DRAIN)
                done_seen_q <= done_seen_q | bus.upsp_done;

            case (state_q)
                S_IDLE: begin
                    // Start wins over a simultaneous abort; abort alone is a no-op.
                    if (bus.cfg_start) begin
                        state_q     <= S_START;
                        up_start_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        row_q       <= '0;
                        col_q       <= '0;
                        done_seen_q <= '0;
                        aborted_q   <= 1'b0;
                        err_stray_q <= 1'b0;
                        err_tlast_q <= 1'b0;
                        frame_ok_q  <= 1'b0;
                    end
                end
                S_START: begin
                    if (bus.cfg_abort) begin
                        state_q    <= S_END;
                        aborted_q  <= 1'b1;
                        up_end_q   <= 1'b1;
                        irq_done_q <= 1'b1;
                    end else begin
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (bus.in_hsk) begin
                        if (cnt_q != '1)
                            cnt_q <= cnt_q + CRF_DATA_WIDTH'(1);
                        if (col_at_last) begin
                            col_q <= '0;
                            row_q <= row_q + ROW_W'(1);
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                        // tlast must coincide exactly with the last column.
                        if (bus.in_tlast != col_at_last)
                            err_tlast_q <= 1'b1;
                    end
                    if (bus.cfg_abort) begin
                        state_q    <= S_END;
                        aborted_q  <= 1'b1;
                        up_end_q   <= 1'b1;
                        irq_done_q <= 1'b1;
                    end else if (bus.in_hsk && cnt_q == PIX_M1) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.cfg_abort) begin
                        state_q    <= S_END;
                        aborted_q  <= 1'b1;
                        up_end_q   <= 1'b1;
                        irq_done_q <= 1'b1;
                    end else if (done_all) begin
                        state_q    <= S_END;
                        up_end_q   <= 1'b1;
                        irq_done_q <= 1'b1;
                    end
                end
                S_END: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    // A stray beat landing in this very cycle also spoils the frame.
                    if (!aborted_q && !err_stray_q && !err_tlast_q && !bus.in_hsk)
                        frame_ok_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Placed after the case so a beat alongside an accepted start
            // is still recorded rather than wiped by the status clear.
            if (bus.in_hsk && state_q != S_STREAM)
                err_stray_q <= 1'b1;
        end
    end

    assign bus.up_start    = up_start_q;
    assign bus.up_end      = up_end_q;
    assign bus.irq_done    = irq_done_q;
    assign bus.busy        = busy_q;
    assign bus.up_inhskcnt = cnt_q;
    assign bus.row_cnt     = row_q;
    assign bus.status      = {aborted_q, err_stray_q, err_tlast_q, frame_ok_q};
endmodule

// File: tb/tb_upsp_frame_ctrl.sv
// tb_upsp_frame_ctrl
//   Directed bench for upsp_frame_ctrl at an 8x4 image with 2 elements.
//   Expected end-of-frame results are queued when a frame is driven and
//   compared when UPEND appears.
module tb_upsp_frame_ctrl;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int N  = 2;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    upsp_frame_ctrl_if #(.N_PARALLEL(N), .CRF_DATA_WIDTH(DW), .SRC_IMG_HEIGHT(H)) bus ();

    upsp_frame_ctrl #(
        .SRC_IMG_WIDTH (W),
        .SRC_IMG_HEIGHT(H),
        .N_PARALLEL    (N),
        .CRF_DATA_WIDTH(DW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] cnt;
        logic [31:0] row;
        logic [31:0] st;
    } exp_t;

    exp_t sb[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic last);
        bus.in_hsk   = 1'b1;
        bus.in_tlast = last;
        tick();
        bus.in_hsk   = 1'b0;
        bus.in_tlast = 1'b0;
    endtask

    // Beats first..first+n-1 of the frame; tlast on every row end plus
    // optionally at index bad.
    task automatic run_beats(input int n, input int first, input int bad);
        for (int i = 0; i < n; i++) begin
            int idx;
            idx = first + i;
            beat(((idx % W) == W - 1) || (idx == bad));
        end
    endtask

    task automatic start_frame();
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        chk("up_start_pulse", 32'(bus.up_start), 32'd1);
        chk("busy_in_start", 32'(bus.busy), 32'd1);
        chk("status_clear", 32'(bus.status), 32'd0);
        chk("cnt_clear", bus.up_inhskcnt, 32'd0);
        chk("row_clear", 32'(bus.row_cnt), 32'd0);
        tick();
        chk("up_start_single", 32'(bus.up_start), 32'd0);
    endtask

    task automatic wait_end(input int budget);
        exp_t e;
        int   n;
        n = 0;
        while (!bus.up_end && n < budget) begin
            tick();
            n++;
        end
        chk("up_end_seen", 32'(bus.up_end), 32'd1);
        chk("irq_done_seen", 32'(bus.irq_done), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
        end else begin
            e.cnt = '0; e.row = '0; e.st = '0;
            miscompares++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end
        chk("end_cnt", bus.up_inhskcnt, e.cnt);
        chk("end_row", 32'(bus.row_cnt), e.row);
        tick();
        chk("up_end_single", 32'(bus.up_end), 32'd0);
        chk("irq_single", 32'(bus.irq_done), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("status_after_end", 32'(bus.status), e.st);
    endtask

    task automatic finish_done();
        bus.upsp_done = 2'b11;
        tick();
        bus.upsp_done = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cfg_start = 1'b0;
        bus.cfg_abort = 1'b0;
        bus.in_hsk    = 1'b0;
        bus.in_tlast  = 1'b0;
        bus.upsp_done = '0;

        // Reset state
        tick();
        chk("rst_up_start", 32'(bus.up_start), 32'd0);
        chk("rst_up_end", 32'(bus.up_end), 32'd0);
        chk("rst_cnt", bus.up_inhskcnt, 32'd0);
        chk("rst_row", 32'(bus.row_cnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_irq", 32'(bus.irq_done), 32'd0);
        chk("rst_status", 32'(bus.status), 32'd0);
        rst_n = 1'b1;
        tick();

        // Nominal frame
        start_frame();
        sb.push_back('{cnt: 32'd32, row: 32'd4, st: 32'b0001});
        run_beats(32, 0, -1);
        chk("nom_busy_drain", 32'(bus.busy), 32'd1);
        finish_done();
        wait_end(4);

        // Staggered done: element 0 early, element 1 ten cycles after last beat
        start_frame();
        sb.push_back('{cnt: 32'd32, row: 32'd4, st: 32'b0001});
        run_beats(3, 0, -1);
        bus.upsp_done = 2'b01;
        run_beats(1, 3, -1);
        bus.upsp_done = 2'b00;
        run_beats(28, 4, -1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("drain_hold_noend", 32'(bus.up_end), 32'd0);
        end
        chk("drain_hold_busy", 32'(bus.busy), 32'd1);
        bus.upsp_done = 2'b10;
        tick();
        bus.upsp_done = 2'b00;
        chk("stagger_end_next", 32'(bus.up_end), 32'd1);
        wait_end(0);

        // tlast on beat 5 of row 0
        start_frame();
        sb.push_back('{cnt: 32'd32, row: 32'd4, st: 32'b0010});
        run_beats(5, 0, 4);
        chk("tlast_err_set", 32'(bus.status[1]), 32'd1);
        run_beats(27, 5, -1);
        chk("tlast_cnt_32", bus.up_inhskcnt, 32'd32);
        finish_done();
        wait_end(4);

        // Abort after 12 beats
        start_frame();
        sb.push_back('{cnt: 32'd12, row: 32'd1, st: 32'b1000});
        run_beats(12, 0, -1);
        bus.cfg_abort = 1'b1;
        tick();
        bus.cfg_abort = 1'b0;
        chk("abort_end_next", 32'(bus.up_end), 32'd1);
        wait_end(0);
        beat(1'b0);
        chk("abort_stray_status", 32'(bus.status), 32'b1100);
        chk("abort_stray_cnt", bus.up_inhskcnt, 32'd12);

        // Start clears status; a second start while busy is ignored
        start_frame();
        sb.push_back('{cnt: 32'd32, row: 32'd4, st: 32'b0001});
        run_beats(3, 0, -1);
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        chk("busy_start_ignored", 32'(bus.up_start), 32'd0);
        tick();
        chk("busy_start_ignored2", 32'(bus.up_start), 32'd0);
        run_beats(29, 3, -1);
        finish_done();
        wait_end(4);
        beat(1'b0);
        chk("idle_stray_status", 32'(bus.status), 32'b0101);
        chk("idle_stray_cnt", bus.up_inhskcnt, 32'd32);

        // Reset mid-frame
        start_frame();
        run_beats(20, 0, -1);
        chk("pre_rst_cnt", bus.up_inhskcnt, 32'd20);
        rst_n = 1'b0;
        #2;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_cnt", bus.up_inhskcnt, 32'd0);
        chk("midrst_row", 32'(bus.row_cnt), 32'd0);
        chk("midrst_status", 32'(bus.status), 32'd0);
        chk("midrst_up_end", 32'(bus.up_end), 32'd0);
        tick();
        chk("midrst_no_end", 32'(bus.up_end), 32'd0);
        chk("midrst_no_irq", 32'(bus.irq_done), 32'd0);
        rst_n = 1'b1;
        tick();
        start_frame();
        sb.push_back('{cnt: 32'd32, row: 32'd4, st: 32'b0001});
        run_beats(1, 0, -1);
        chk("post_rst_first", bus.up_inhskcnt, 32'd1);
        run_beats(31, 1, -1);
        finish_done();
        wait_end(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/upsp_frame_ctrl.md
Name: upsp_frame_ctrl

Overview:
- Frame-level sequencer for the AXI-Stream input path into Up-Sampling.
- Turns a configuration start/abort request into the one-cycle UPSTART/UPEND pulses, and counts accepted input handshakes to produce UPINHSKCNT.
- Checks row (tlast) alignment and collects per-element done flags from the N_PARALLEL upsp elements.
- Sits between the configuration register file and the stream-in / upsp datapath.

Parameters:
- SRC_IMG_WIDTH, 1920: source pixels per row.
- SRC_IMG_HEIGHT, 1080: source rows per frame.
- N_PARALLEL, 2: number of upsp processing elements.
- CRF_DATA_WIDTH, 32: width of the handshake counter and status word.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- cfg_start  input  1  one-cycle start request from the configuration register file.
- cfg_abort  input  1  one-cycle abort request.
- in_hsk  input  1  accepted input beat (tvalid & tready of the stream slave).
- in_tlast  input  1  tlast qualifying in_hsk.
- upsp_done  input  N_PARALLEL  per-element completion pulse or level.
- up_start  output  1  UPSTART pulse.
- up_end  output  1  UPEND pulse.
- up_inhskcnt  output  CRF_DATA_WIDTH  accepted beats in the current or last frame.
- row_cnt  output  clog2(SRC_IMG_HEIGHT+1)  completed input rows.
- busy  output  1  high in every state except IDLE.
- irq_done  output  1  one-cycle frame-complete pulse.
- status  output  4  {aborted, err_stray, err_tlast, frame_ok}, all sticky.

Behaviour:
- Reset values: every output is 0, and the state is IDLE.
- Constants: PIX = SRC_IMG_WIDTH*SRC_IMG_HEIGHT.
- Internal col counter: 0..SRC_IMG_WIDTH-1.
- Internal done_seen register: N_PARALLEL bits.

State machine:
- IDLE: cfg_start -> START.
  - On accepting cfg_start, clear status, up_inhskcnt, row_cnt, col and done_seen in the same edge.
  - cfg_abort in IDLE is a no-op. If cfg_start and cfg_abort arrive together in IDLE, the start is taken.
- START: up_start=1 for exactly this one cycle, then -> STREAM unconditionally unless cfg_abort.
- STREAM: on each in_hsk, up_inhskcnt increments (saturating at all-ones).
  - col increments, wrapping to 0 at SRC_IMG_WIDTH-1.
  - row_cnt increments when col wraps.
  - When in_hsk occurs with up_inhskcnt == PIX-1 -> DRAIN.
- DRAIN: wait until done_seen is all-ones -> END.
- END: up_end=1 and irq_done=1 for exactly one cycle.
  - frame_ok is set if not aborted and no error bit is set.
  - Then -> IDLE.
- cfg_abort in START, STREAM or DRAIN: -> END next cycle, set aborted; frame_ok stays 0.

Pulse timing:
- up_start is high the cycle after cfg_start is sampled.
- up_end is high the cycle after the terminating condition is sampled (last DRAIN cycle or abort).

done_seen:
- done_seen[i] is set by upsp_done[i] in STREAM or DRAIN.
- A done arriving in the same cycle as the final beat counts.

tlast checks:
- err_tlast is set on in_hsk & in_tlast with col != SRC_IMG_WIDTH-1.
- err_tlast is also set on in_hsk & ~in_tlast with col == SRC_IMG_WIDTH-1.
- Counting continues unchanged after an error; there is no resync.

Stray beats and ignored requests:
- in_hsk in IDLE, START, DRAIN or END sets err_stray. It is not counted.
- cfg_start while busy is ignored.

Hold and reset:
- up_inhskcnt, row_cnt and status hold their values after END until the next accepted cfg_start.
- Asserting rst_n low mid-frame returns the block to IDLE with all outputs 0 asynchronously. No up_end is emitted.

Test Plan:
All scenarios use SRC_IMG_WIDTH=8, SRC_IMG_HEIGHT=4, N_PARALLEL=2 (PIX=32).
- Nominal frame: cfg_start, 32 in_hsk beats with tlast on every 8th, upsp_done=2'b11 after the last beat.
  - Required: up_start one cycle after cfg_start; up_inhskcnt=32; row_cnt=4.
  - Required: up_end and irq_done single pulses; status=4'b0001.
- Staggered done: upsp_done[0] arrives during STREAM, upsp_done[1] arrives 10 cycles after the last beat.
  - Required: stays in DRAIN for those cycles; up_end exactly one cycle after upsp_done[1].
- tlast misalignment: tlast on beat 5 of row 0.
  - Required: err_tlast=1; count still reaches 32; status=4'b0010 after END.
- Abort: cfg_abort after 12 beats.
  - Required: up_end next cycle; up_inhskcnt=12; status=4'b1000.
  - Required: a further in_hsk sets err_stray (status=4'b1100); cfg_start then clears status to 0.
- Ignored start and stray: cfg_start while busy -> no second up_start. in_hsk in IDLE -> err_stray=1 and up_inhskcnt unchanged.
- Reset mid-frame: rst_n low after 20 beats.
  - Required: all outputs 0 immediately; no up_end; a new frame after release counts from 0.
